// File: rtl/nec_prefetch_pkg.sv
// Shared types for the instruction prefetch unit: FSM states, queue size, address helper.
package nec_prefetch_pkg;

  localparam int IPQ_SIZE = 8;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_REQ  = 1'b1
  } prefetch_state_e;

  // Segment:offset to 20-bit physical address, forced to a word boundary.
  function automatic logic [19:0] phys_word(input logic [15:0] seg, input logic [15:0] ip);
    logic [19:0] a;
    a = {seg, 4'h0} + {4'h0, ip};
    return {a[19:1], 1'b0};
  endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch: fetches code words into an 8-byte circular queue, one request in flight.
// Latency: request one cycle after issue decision; bytes visible one cycle after ack; fetch_hold blocks issue only.
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter int FETCH_MIN_FREE = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic [15:0]              ps,
  input  logic                     set_pc,
  input  logic [15:0]              new_pc,
  input  logic                     consume,
  input  logic [3:0]               consume_len,
  input  logic                     fetch_hold,
  output logic [IPQ_SIZE-1:0][7:0] ipq,
  output logic [3:0]               ipq_len,
  output logic                     fetch_req,
  output logic [19:0]              fetch_addr,
  input  logic                     fetch_ack,
  input  logic [15:0]              fetch_data
);

  localparam logic [3:0] MIN_FREE = 4'(FETCH_MIN_FREE);
  localparam logic [3:0] QSIZE    = 4'(IPQ_SIZE);

  prefetch_state_e state;
  logic [15:0]     fetch_ip;
  logic            discard;

  logic [3:0] len_after_consume;
  logic [3:0] wr_cnt;
  logic [3:0] len_next;
  logic [3:0] free_next;
  logic       odd_ip;
  logic       ack_ok;
  logic       issue;
  logic [2:0] slot;
  logic [2:0] slot_nx;

  always_comb begin
    len_after_consume = ipq_len;
    if (consume)
      len_after_consume = (consume_len > ipq_len) ? 4'd0 : ipq_len - consume_len;
    odd_ip    = fetch_ip[0];
    slot      = fetch_ip[2:0];
    slot_nx   = fetch_ip[2:0] + 3'd1;
    // Data landing during a flush, or belonging to a flushed request, is dropped.
    ack_ok    = (state == PF_REQ) && fetch_ack && !discard && !set_pc;
    wr_cnt    = ack_ok ? (odd_ip ? 4'd1 : 4'd2) : 4'd0;
    len_next  = set_pc ? 4'd0 : len_after_consume + wr_cnt;
    free_next = QSIZE - len_next;
    // An even address always writes two bytes, so it never issues into a single free slot.
    issue     = (state == PF_IDLE) && !fetch_hold && !set_pc &&
                (free_next >= MIN_FREE) && (odd_ip || free_next >= 4'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= PF_IDLE;
      fetch_ip   <= 16'h0000;
      discard    <= 1'b0;
      ipq_len    <= 4'd0;
      fetch_req  <= 1'b0;
      fetch_addr <= 20'h00000;
      ipq        <= '0;
    end else if (ce) begin
      ipq_len <= len_next;
      if (set_pc)
        fetch_ip <= new_pc;
      case (state)
        PF_IDLE: begin
          if (issue) begin
            state      <= PF_REQ;
            fetch_req  <= 1'b1;
            fetch_addr <= phys_word(ps, fetch_ip);
          end
        end
        PF_REQ: begin
          if (fetch_ack) begin
            state     <= PF_IDLE;
            fetch_req <= 1'b0;
            discard   <= 1'b0;
            if (ack_ok) begin
              if (odd_ip) begin
                ipq[slot] <= fetch_data[15:8];
                fetch_ip  <= fetch_ip + 16'd1;
              end else begin
                ipq[slot]    <= fetch_data[7:0];
                ipq[slot_nx] <= fetch_data[15:8];
                fetch_ip     <= fetch_ip + 16'd2;
              end
            end
          end else if (set_pc) begin
            discard <= 1'b1;
          end
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

  // Decoder must never retire more bytes than are valid.
  a_consume_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    (ce && consume && !set_pc) |-> (consume_len <= ipq_len));

endmodule
